// File: rtl/platform_scroll_ctrl_pkg.sv
// Shared constants, FSM state encoding and table entry type for the platform scroll controller.
package plat_pkg;
  localparam int NUM_PLAT     = 16;
  localparam int IDX_W        = 4;
  localparam int PLAT_SPACING = 30;
  localparam int SCREEN_H     = 480;
  localparam int SCROLL_LINE  = 200;
  localparam int MAX_STEP     = 8;
  localparam int X_OFFSET     = 64;
  localparam int X_RESET      = 320;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_WALK,
    ST_WAIT_RND,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } plat_pos_t;

  // Scroll only while the ball is rising above the scroll line, capped per frame.
  function automatic logic [9:0] calc_shift(input logic [9:0] ball_y, input logic rising);
    logic [9:0] diff;
    diff = 10'(SCROLL_LINE) - ball_y;
    if (!rising || ball_y >= 10'(SCROLL_LINE)) return '0;
    return (diff > 10'(MAX_STEP)) ? 10'(MAX_STEP) : diff;
  endfunction
endpackage

// File: rtl/platform_scroll_ctrl_if.sv
// Random-value request handshake between the scroll controller (master) and the LFSR chain (slave).
interface platform_scroll_ctrl_if;
  logic       rnd_req;
  logic [8:0] rnd_data;
  logic       rnd_valid;

  modport master (output rnd_req, input rnd_data, input rnd_valid);
  modport slave  (input rnd_req, output rnd_data, output rnd_valid);
endinterface

// File: rtl/platform_scroll_ctrl_edge_sync.sv
// Two-flop synchroniser for the frame strobe plus a one-cycle rising-edge pulse.
module plat_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic rise_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/platform_scroll_ctrl.sv
// Platform position table owner: per-frame scroll decision, table walk and recycling of platforms.
// Optional score accumulator is built when PLAT_SCORE_EN is defined.
//
//   state       | meaning
//   ST_INIT     | fetch a random X for every entry after reset
//   ST_IDLE     | wait for a frame event
//   ST_CALC     | compute this frame's shift from the ball position
//   ST_WALK     | shift one entry down per cycle
//   ST_WAIT_RND | entry fell off the bottom; waiting for its new random X
//   ST_DONE     | publish scroll_amt with a one-cycle scroll_valid
module platform_scroll_ctrl
  import plat_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  BallY,
  input  logic        ball_rising,
  platform_scroll_ctrl_if.master rnd,
  input  logic [3:0]  rd_idx,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic [9:0]  scroll_amt,
  output logic        scroll_valid,
`ifdef PLAT_SCORE_EN
  input  logic        score_clr,
  output logic [15:0] score,
`endif
  output logic        busy
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       shift_q, shift_d;
  logic             rnd_req_q, rnd_req_d;
  logic             busy_q;
  logic [9:0]       scroll_amt_q, rd_x_q, rd_y_q;
  plat_pos_t        tbl_q [NUM_PLAT];

  logic             frame_evt, accept, wrap;
  logic [9:0]       calc_sh, x_new, y_next;
  logic [10:0]      sum;

  plat_edge_sync u_frame_sync (
    .clk_i   (Clk),
    .rst_n_i (Reset),
    .async_i (frame_clk),
    .rise_o  (frame_evt)
  );

  assign calc_sh = calc_shift(BallY, ball_rising);
  assign accept  = rnd_req_q & rnd.rnd_valid;
  assign sum     = {1'b0, tbl_q[idx_q].y} + {1'b0, shift_q};
  assign wrap    = sum >= 11'(SCREEN_H);
  assign y_next  = wrap ? 10'(sum - 11'(SCREEN_H)) : sum[9:0];
  assign x_new   = {1'b0, rnd.rnd_data} + 10'(X_OFFSET);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     if (accept && idx_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:     if (frame_evt) state_d = ST_CALC;
      ST_CALC:     state_d = (calc_sh == '0) ? ST_DONE : ST_WALK;
      ST_WALK: begin
        if (wrap)                  state_d = ST_WAIT_RND;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_WAIT_RND: if (accept) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_WALK;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // Request drops for at least one cycle after every accepted value.
  always_comb begin
    rnd_req_d    = 1'b0;
    scroll_valid = 1'b0;
    if ((state_d == ST_INIT || state_d == ST_WAIT_RND) && !accept) rnd_req_d = 1'b1;
    if (state_q == ST_DONE) scroll_valid = 1'b1;
  end

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      ST_INIT:     if (accept) idx_d = idx_q + IDX_W'(1);
      ST_CALC: begin
        idx_d   = '0;
        shift_d = calc_sh;
      end
      ST_WALK:     if (!wrap) idx_d = idx_q + IDX_W'(1);
      ST_WAIT_RND: if (accept) idx_d = idx_q + IDX_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx_q        <= '0;
      shift_q      <= '0;
      rnd_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      scroll_amt_q <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        tbl_q[i].x <= 10'(X_RESET);
        tbl_q[i].y <= 10'(PLAT_SPACING * (i + 1));
      end
    end else begin
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rnd_req_q <= rnd_req_d;
      busy_q    <= (state_d != ST_IDLE);
      if (state_d == ST_DONE) scroll_amt_q <= shift_d;
      rd_x_q <= tbl_q[rd_idx].x;
      rd_y_q <= tbl_q[rd_idx].y;
      if (state_q == ST_WALK) tbl_q[idx_q].y <= y_next;
      if (accept) tbl_q[idx_q].x <= x_new;
    end
  end

`ifdef PLAT_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + 17'(shift_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                  score_q <= '0;
    else if (score_clr)          score_q <= '0;
    else if (state_q == ST_DONE) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign score = score_q;
`endif

  assign rnd.rnd_req = rnd_req_q;
  assign busy        = busy_q;
  assign scroll_amt  = scroll_amt_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// Scoreboard bench for platform_scroll_ctrl: stimulus queues expected scroll amounts and table reads,
// a monitor pops and compares when the DUT presents them.
module tb_platform_scroll_ctrl;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] BallY;
  logic       ball_rising;
  logic [3:0] rd_idx;
  logic [9:0] rd_x, rd_y, scroll_amt;
  logic       scroll_valid, busy;
`ifdef PLAT_SCORE_EN
  logic        score_clr;
  logic [15:0] score;
`endif

  platform_scroll_ctrl_if rif ();

  platform_scroll_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .BallY        (BallY),
    .ball_rising  (ball_rising),
    .rnd          (rif),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .scroll_amt   (scroll_amt),
    .scroll_valid (scroll_valid),
`ifdef PLAT_SCORE_EN
    .score_clr    (score_clr),
    .score        (score),
`endif
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int    x;
    int    y;
    string name;
  } rd_exp_t;

  int      errors = 0;
  int      checks = 0;
  int      hs_cnt = 0;
  int      sv_cnt = 0;
  int      rnd_uflow = 0;
  int      rnd_delay = 0;
  int      pat_n = 0;
  int      sc_q[$];
  int      rnd_q[$];
  rd_exp_t rd_q[$];
  int      y_m[16];
  logic    rd_issue = 1'b0;
  logic    rd_cap = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(posedge Clk) rd_cap <= rd_issue;

  // Monitor: scroll pulses and registered table reads
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge Clk);
      if (scroll_valid) begin
        sv_cnt++;
        if (sc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scroll_unexpected: pulse with scroll_amt=%0d, required no pulse", scroll_amt);
        end else begin
          chk("scroll_amt", int'(scroll_amt), sc_q.pop_front());
        end
      end
      if (rd_cap) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: read with no expectation queued");
        end else begin
          e = rd_q.pop_front();
          if (e.x >= 0) chk({e.name, "_x"}, int'(rd_x), e.x);
          if (e.y >= 0) chk({e.name, "_y"}, int'(rd_y), e.y);
        end
      end
    end
  end

  // LFSR stand-in: answers each request after rnd_delay cycles with the next queued value
  initial begin
    rif.rnd_valid = 1'b0;
    rif.rnd_data  = '0;
    forever begin
      @(negedge Clk);
      if (rif.rnd_req) begin
        repeat (rnd_delay) @(negedge Clk);
        if (rnd_q.size() == 0) begin
          rnd_uflow++;
          rif.rnd_data = '0;
        end else begin
          rif.rnd_data = 9'(rnd_q.pop_front());
        end
        rif.rnd_valid = 1'b1;
        hs_cnt++;
        @(negedge Clk);
        rif.rnd_valid = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic rd_chk(input int idx, input int ex_x, input int ex_y, input string name);
    rd_exp_t e;
    e.x = ex_x;
    e.y = ex_y;
    e.name = name;
    rd_q.push_back(e);
    rd_idx   = 4'(idx);
    rd_issue = 1'b1;
    @(negedge Clk);
    rd_issue = 1'b0;
  endtask

  task automatic wait_busy_low(input string name);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      @(negedge Clk);
    end
    chk({name, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic chk_outs_zero(input string name);
    chk({name, "_rd_x"}, int'(rd_x), 0);
    chk({name, "_rd_y"}, int'(rd_y), 0);
    chk({name, "_scroll_amt"}, int'(scroll_amt), 0);
    chk({name, "_scroll_valid"}, int'(scroll_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_rnd_req"}, int'(rif.rnd_req), 0);
  endtask

  // Table Y model; pushes one random value per recycled entry, in walk order
  task automatic model_frame(input int sh, input int forced);
    for (int i = 0; i < 16; i++) begin
      y_m[i] += sh;
      if (y_m[i] >= 480) begin
        y_m[i] -= 480;
        if (forced >= 0) rnd_q.push_back(forced);
        else begin
          rnd_q.push_back((pat_n * 53 + 7) % 512);
          pat_n++;
        end
      end
    end
  endtask

  task automatic do_frame(input int by, input bit rising, input int sh, input int forced);
    BallY       = 10'(by);
    ball_rising = rising;
    model_frame(sh, forced);
    sc_q.push_back(sh);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    wait_busy_low("frame");
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int hs0, sv0, lows;
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    BallY       = 10'd300;
    ball_rising = 1'b0;
    rd_idx      = '0;
`ifdef PLAT_SCORE_EN
    score_clr   = 1'b0;
`endif
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk_outs_zero("reset");

    for (int i = 0; i < 16; i++) begin
      y_m[i] = 30 * (i + 1);
      rnd_q.push_back(i);
    end
    Reset = 1'b1;
    @(negedge Clk);
    chk("init_busy_high", int'(busy), 1);
    wait_busy_low("init");
    chk("init_handshakes", hs_cnt, 16);
    for (int i = 0; i < 16; i++) rd_chk(i, 64 + i, 30 * (i + 1), "init");

    hs0 = hs_cnt;
    do_frame(150, 1'b1, 8, 100);
    chk("f1_handshakes", hs_cnt - hs0, 1);
    rd_chk(0, -1, 38, "f1_e0");
    rd_chk(14, -1, 458, "f1_e14");
    rd_chk(15, 164, 8, "f1_e15");

    repeat (58) do_frame(192, 1'b1, 8, -1);
    do_frame(196, 1'b1, 4, -1);
    rd_chk(0, -1, 26, "setup_e0");
    rd_chk(7, -1, 236, "setup_e7");
    rd_chk(15, -1, 476, "setup_e15");

    hs0 = hs_cnt;
    do_frame(150, 1'b1, 8, 511);
    chk("wrap_handshakes", hs_cnt - hs0, 1);
    rd_chk(15, 575, 4, "wrap_e15");
    rd_chk(0, -1, 34, "wrap_e0");
    rd_chk(14, -1, 454, "wrap_e14");

    hs0 = hs_cnt;
    do_frame(200, 1'b1, 0, -1);
    rd_chk(0, -1, 34, "line_e0");
    rd_chk(15, 575, 4, "line_e15");
    do_frame(100, 1'b0, 0, -1);
    rd_chk(14, -1, 454, "falling_e14");
    rd_chk(15, 575, 4, "falling_e15");
    chk("noscroll_handshakes", hs_cnt - hs0, 0);

    repeat (3) do_frame(150, 1'b1, 8, -1);

    hs0 = hs_cnt;
    sv0 = sv_cnt;
    rnd_delay   = 20;
    BallY       = 10'd150;
    ball_rising = 1'b1;
    model_frame(8, 300);
    sc_q.push_back(8);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    chk("second_edge_busy", int'(busy), 1);
    for (int k = 0; k < 100; k++) begin
      if (rif.rnd_req) break;
      @(negedge Clk);
    end
    chk("delay_req_seen", int'(rif.rnd_req), 1);
    lows = 0;
    repeat (20) begin
      @(negedge Clk);
      if (!rif.rnd_req) lows++;
    end
    chk("delay_req_held", lows, 0);
    wait_busy_low("delay");
    repeat (10) @(negedge Clk);
    chk("delay_single_pulse", sv_cnt - sv0, 1);
    chk("delay_handshakes", hs_cnt - hs0, 1);
    chk("dropped_edge_idle", int'(busy), 0);
    rnd_delay = 0;
    rd_chk(14, 364, 6, "delay_e14");
    rd_chk(15, -1, 36, "delay_e15");

    rd_idx      = 4'd5;
    BallY       = 10'd150;
    ball_rising = 1'b1;
    frame_clk   = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    chk("midwalk_busy", int'(busy), 1);
    Reset = 1'b0;
    #1;
    chk_outs_zero("midwalk_reset");
    for (int i = 0; i < 16; i++) begin
      y_m[i] = 30 * (i + 1);
      rnd_q.push_back(200 + i);
    end
    hs0 = hs_cnt;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    wait_busy_low("reinit");
    chk("reinit_handshakes", hs_cnt - hs0, 16);
    rd_chk(0, 264, 30, "reinit_e0");
    rd_chk(14, 278, 450, "reinit_e14");
    rd_chk(15, 279, 480, "reinit_e15");

    repeat (3) @(negedge Clk);
    chk("scroll_queue_left", sc_q.size(), 0);
    chk("read_queue_left", rd_q.size(), 0);
    chk("rnd_underflow", rnd_uflow, 0);
    chk("rnd_values_left", rnd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
